// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared types for the memory stage and its operand lookups.
//   int_t                  32-bit machine word
//   register_id_t          5-bit architectural register id
//   stage_register_data_t  one later-stage result {registerId, dataReady, data}
//   stage_register_array_t results of the default number of later stages
//   NO_SUCH_STAGE          filler entry for a stage that does not exist
package data_memory_pkg;
    typedef logic [31:0] int_t;
    typedef logic [4:0] register_id_t;

    typedef struct packed {
        register_id_t registerId;
        logic         dataReady;
        int_t         data;
    } stage_register_data_t;

    localparam int DEFAULT_NSTAGES = 3;

    typedef stage_register_data_t stage_register_array_t [DEFAULT_NSTAGES];

    // Register 0 never matches a source, so this entry can never forward or stall.
    localparam stage_register_data_t NO_SUCH_STAGE = '{registerId: '0, dataReady: 1'b1, data: '0};
endpackage

// File: rtl/data_memory_hazard.sv
// hazard_unit: resolves one source operand against results held in later stages.
//   clock, reset           interface uniformity; the lookup is combinational (reset masks stall)
//   program_counter        debug trace only
//   register_id            source register; 0 never forwards
//   original_data          register-file value
//   stall_count            number of nearest stage entries to skip
//   data_from_next_stages  later-stage results, index 0 nearest
//   forwarded_data         resolved operand
//   stall                  the nearest matching stage has no valid value yet
module hazard_unit
    import data_memory_pkg::*;
#(
    parameter int NSTAGES = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  int_t                 program_counter,
    input  register_id_t         register_id,
    input  int_t                 original_data,
    input  logic [1:0]           stall_count,
    input  stage_register_data_t data_from_next_stages [NSTAGES],
    output int_t                 forwarded_data,
    output logic                 stall
);
    logic hit;
    logic hitReady;
    int_t hitData;
    logic unusedInputs;

    assign unusedInputs = ^{clock, program_counter};

    // Scan farthest to nearest so the nearest eligible match overwrites the others.
    always_comb begin
        hit = 1'b0;
        hitReady = 1'b0;
        hitData = '0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (k >= int'(stall_count) && register_id != '0 &&
                data_from_next_stages[k].registerId == register_id) begin
                hit = 1'b1;
                hitReady = data_from_next_stages[k].dataReady;
                hitData = data_from_next_stages[k].data;
            end
        end
    end

    assign forwarded_data = hit && hitReady ? hitData : original_data;
    assign stall = !reset && hit && !hitReady;
endmodule

// File: rtl/data_memory.sv
// data_memory: memory-stage word RAM with forwarded store data.
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   program_counter               debug trace only
//   address                       byte address; word index wraps modulo DEPTH
//   write_enabled, write_from     store request; source 1 = operand 1, 0 = operand 2
//   reg_id1/2, reg_data1/2        source registers and their register-file values
//   stall_count                   nearest stage entries to ignore
//   stage_reg_id/ready/data       packed later-stage results, entry 0 nearest
//   data_read                     combinational RAM word at address
//   fwd_data1/2                   resolved operands
//   hazard_stall                  a needed result is not yet available
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int NSTAGES = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             program_counter,
    input  logic [31:0]             address,
    input  logic                    write_enabled,
    input  logic                    write_from,
    input  logic [4:0]              reg_id1,
    input  logic [4:0]              reg_id2,
    input  logic [31:0]             reg_data1,
    input  logic [31:0]             reg_data2,
    input  logic [1:0]              stall_count,
    input  logic [5*NSTAGES-1:0]    stage_reg_id,
    input  logic [NSTAGES-1:0]      stage_ready,
    input  logic [32*NSTAGES-1:0]   stage_data,
    output logic [31:0]             data_read,
    output logic [31:0]             fwd_data1,
    output logic [31:0]             fwd_data2,
    output logic                    hazard_stall
);
    localparam int INDEX_W = $clog2(DEPTH);

    int_t                 mem [DEPTH];
    stage_register_data_t stages [NSTAGES];
    logic [INDEX_W-1:0]   wordIndex;
    logic                 stall1;
    logic                 stall2;
    int_t                 storeData;
    logic                 unusedAddressBits;

    for (genvar i = 0; i < NSTAGES; i++) begin : g_stage
        assign stages[i] = '{registerId: stage_reg_id[5*i +: 5],
                             dataReady:  stage_ready[i],
                             data:       stage_data[32*i +: 32]};
    end

    hazard_unit #(.NSTAGES(NSTAGES)) hazard1 (
        .clock                 (clock),
        .reset                 (reset),
        .program_counter       (program_counter),
        .register_id           (reg_id1),
        .original_data         (reg_data1),
        .stall_count           (stall_count),
        .data_from_next_stages (stages),
        .forwarded_data        (fwd_data1),
        .stall                 (stall1)
    );

    hazard_unit #(.NSTAGES(NSTAGES)) hazard2 (
        .clock                 (clock),
        .reset                 (reset),
        .program_counter       (program_counter),
        .register_id           (reg_id2),
        .original_data         (reg_data2),
        .stall_count           (stall_count),
        .data_from_next_stages (stages),
        .forwarded_data        (fwd_data2),
        .stall                 (stall2)
    );

    // Byte offset and bits above the RAM size are deliberately dropped.
    assign wordIndex = address[INDEX_W+1:2];
    assign unusedAddressBits = ^{address[31:INDEX_W+2], address[1:0]};

    assign hazard_stall = stall1 || stall2;
    assign storeData = write_from ? fwd_data1 : fwd_data2;
    assign data_read = mem[wordIndex];

    // A stalled store is dropped; the pipeline re-presents the instruction.
    always_ff @(posedge clock) begin
        if (write_enabled && !hazard_stall && !reset)
            mem[wordIndex] <= storeData;
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed and randomized checks of data_memory against a reference model.
module tb_data_memory;
    localparam int DEPTH = 1024;
    localparam int NS = 3;

    logic clock = 1'b0;
    logic reset;
    logic [31:0] programCounter, address, regData1, regData2;
    logic writeEnabled, writeFrom;
    logic [4:0] regId1, regId2;
    logic [1:0] stallCount;
    logic [4:0] stId [NS];
    logic stRdy [NS];
    logic [31:0] stDat [NS];
    logic [5*NS-1:0] stageRegId;
    logic [NS-1:0] stageReady;
    logic [32*NS-1:0] stageData;
    logic [31:0] dataRead, fwdData1, fwdData2;
    logic hazardStall;

    logic [31:0] modelMem [DEPTH];
    int checkCount = 0;
    int errorCount = 0;

    always #5 clock = ~clock;

    always_comb begin
        stageRegId = '0;
        stageReady = '0;
        stageData = '0;
        for (int k = 0; k < NS; k++) begin
            stageRegId[5*k +: 5] = stId[k];
            stageReady[k] = stRdy[k];
            stageData[32*k +: 32] = stDat[k];
        end
    end

    data_memory #(.DEPTH(DEPTH), .NSTAGES(NS)) dut (
        .clock           (clock),
        .reset           (reset),
        .program_counter (programCounter),
        .address         (address),
        .write_enabled   (writeEnabled),
        .write_from      (writeFrom),
        .reg_id1         (regId1),
        .reg_id2         (regId2),
        .reg_data1       (regData1),
        .reg_data2       (regData2),
        .stall_count     (stallCount),
        .stage_reg_id    (stageRegId),
        .stage_ready     (stageReady),
        .stage_data      (stageData),
        .data_read       (dataRead),
        .fwd_data1       (fwdData1),
        .fwd_data2       (fwdData2),
        .hazard_stall    (hazardStall)
    );

    task automatic checkValue(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic int wordOf(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // First stage at or beyond stallCount naming the register decides the outcome.
    function automatic void resolve(input logic [4:0] id, input logic [31:0] orig,
                                    output logic [31:0] val, output logic st);
        val = orig;
        st = 1'b0;
        if (id == 0) return;
        for (int k = int'(stallCount); k < NS; k++) begin
            if (stId[k] == id) begin
                if (stRdy[k]) val = stDat[k];
                else st = 1'b1;
                return;
            end
        end
    endfunction

    task automatic cycle();
        logic [31:0] e1, e2;
        logic s1, s2, es;
        #1;
        resolve(regId1, regData1, e1, s1);
        resolve(regId2, regData2, e2, s2);
        es = !reset && (s1 || s2);
        checkValue("fwd1", fwdData1, e1);
        checkValue("fwd2", fwdData2, e2);
        checkValue("stall", {31'b0, hazardStall}, {31'b0, es});
        checkValue("read", dataRead, modelMem[wordOf(address)]);
        @(posedge clock);
        if (writeEnabled && !es && !reset)
            modelMem[wordOf(address)] = writeFrom ? e1 : e2;
        @(negedge clock);
    endtask

    task automatic clearStages();
        for (int k = 0; k < NS; k++) begin
            stId[k] = '0;
            stRdy[k] = 1'b1;
            stDat[k] = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        reset = 1'b1;
        programCounter = '0;
        address = '0;
        writeEnabled = 1'b0;
        writeFrom = 1'b0;
        regId1 = '0;
        regId2 = '0;
        regData1 = '0;
        regData2 = '0;
        stallCount = '0;
        clearStages();
        @(negedge clock);
        @(negedge clock);

        // Reset masks a genuine hazard
        regId1 = 5'd7;
        stId[0] = 5'd7;
        stRdy[0] = 1'b0;
        #1 checkValue("reset_no_stall", {31'b0, hazardStall}, 32'd0);
        cycle();
        reset = 1'b0;
        regId1 = '0;
        clearStages();

        // Store then load, byte offset ignored
        regData2 = 32'hDEADBEEF;
        address = 32'h10;
        writeEnabled = 1'b1;
        cycle();
        writeEnabled = 1'b0;
        #1 checkValue("store_load", dataRead, 32'hDEADBEEF);
        address = 32'h13;
        #1 checkValue("byte_offset", dataRead, 32'hDEADBEEF);
        cycle();

        // Nearest stage wins; stall_count skips it
        regId2 = 5'd5;
        stId[0] = 5'd5; stRdy[0] = 1'b1; stDat[0] = 32'h11;
        stId[1] = 5'd5; stRdy[1] = 1'b1; stDat[1] = 32'h22;
        #1 checkValue("prio_near", fwdData2, 32'h11);
        checkValue("prio_stall", {31'b0, hazardStall}, 32'd0);
        stallCount = 2'd1;
        #1 checkValue("prio_skip", fwdData2, 32'h22);
        stallCount = 2'd3;
        #1 checkValue("skip_all", fwdData2, regData2);
        cycle();
        stallCount = '0;
        clearStages();
        regId2 = '0;

        // Not-ready hazard drops the store
        regId1 = 5'd7;
        stId[0] = 5'd7; stRdy[0] = 1'b0;
        stId[1] = 5'd7; stRdy[1] = 1'b1; stDat[1] = 32'h33;
        address = 32'h20;
        regData2 = 32'h12345678;
        writeEnabled = 1'b1;
        #1 checkValue("hazard_stall", {31'b0, hazardStall}, 32'd1);
        cycle();
        writeEnabled = 1'b0;
        #1 checkValue("hazard_no_write", dataRead, 32'd0);
        clearStages();

        // Register 0 never forwards
        regId1 = '0;
        regData1 = 32'h55;
        stId[0] = '0; stRdy[0] = 1'b1; stDat[0] = 32'h99;
        #1 checkValue("reg0_data", fwdData1, 32'h55);
        checkValue("reg0_stall", {31'b0, hazardStall}, 32'd0);
        cycle();

        // Address wrap, with and without reset
        writeFrom = 1'b1;
        regData1 = 32'hA5;
        address = 4 * DEPTH;
        writeEnabled = 1'b1;
        reset = 1'b1;
        cycle();
        writeEnabled = 1'b0;
        reset = 1'b0;
        address = '0;
        #1 checkValue("wrap_reset", dataRead, 32'd0);
        address = 4 * DEPTH;
        writeEnabled = 1'b1;
        cycle();
        writeEnabled = 1'b0;
        address = '0;
        #1 checkValue("wrap_write", dataRead, 32'hA5);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 15) == 0);
            programCounter = $urandom();
            address = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            writeEnabled = $urandom_range(0, 1) == 1;
            writeFrom = $urandom_range(0, 1) == 1;
            regId1 = 5'($urandom_range(0, 7));
            regId2 = 5'($urandom_range(0, 7));
            regData1 = $urandom();
            regData2 = $urandom();
            stallCount = 2'($urandom_range(0, 3));
            for (int k = 0; k < NS; k++) begin
                stId[k] = 5'($urandom_range(0, 7));
                stRdy[k] = $urandom_range(0, 3) != 0;
                stDat[k] = $urandom();
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
